// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time / period capture with stuck-line and overflow flags.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             pwm_clk,
  input  logic             pwm_reset,
  input  logic             pwm_en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] cap_high,
  output logic [WIDTH-1:0] cap_period,
  output logic             cap_valid,
  output logic             cap_stuck,
  output logic             cap_level,
  output logic             cap_ovf
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = '1;
  localparam logic [WIDTH-1:0] TO_CNT  = WIDTH'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall;
  logic                   rise_q, fall_q, lvl_q;
  logic [WIDTH-1:0]       cnt, age, hi_lat;
  logic                   ovf_int, stuck_done;
  logic                   pub_meas, pub_stuck;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Edge strobes are registered once more; the FSM works on rise_q/fall_q and lvl_q.
  always_ff @(posedge pwm_clk) begin
    if (pwm_reset) begin
      sync   <= '0;
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
      rise_q <= rise;
      fall_q <= fall;
      lvl_q  <= s;
    end
  end

  always_comb begin
    state_d   = state_q;
    pub_meas  = 1'b0;
    pub_stuck = 1'b0;
    if (!pwm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_q)
            state_d = MEAS;
          else if (!fall_q && age == TO_CNT && !stuck_done)
            pub_stuck = 1'b1;
        end
        MEAS: begin
          // An edge always beats the timeout: the line is demonstrably toggling.
          if (rise_q) begin
            pub_meas = 1'b1;
          end else if (!fall_q && age == TO_CNT) begin
            pub_stuck = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pwm_clk) begin
    if (pwm_reset) begin
      state_q    <= IDLE;
      cnt        <= '0;
      age        <= '0;
      hi_lat     <= '0;
      ovf_int    <= 1'b0;
      stuck_done <= 1'b0;
      cap_high   <= '0;
      cap_period <= '0;
      cap_valid  <= 1'b0;
      cap_stuck  <= 1'b0;
      cap_level  <= 1'b0;
      cap_ovf    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_valid <= 1'b0;
      if (!pwm_en) begin
        cnt        <= '0;
        age        <= '0;
        hi_lat     <= '0;
        ovf_int    <= 1'b0;
        stuck_done <= 1'b0;
      end else begin
        if (rise_q || fall_q)
          age <= '0;
        else if (age != TO_CNT)
          age <= age + 1'b1;

        if (rise_q || fall_q)
          stuck_done <= 1'b0;
        else if (pub_stuck)
          stuck_done <= 1'b1;

        if (rise_q) begin
          cnt     <= {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_int <= 1'b0;
        end else if (state_q == MEAS) begin
          if (cnt == MAX_CNT)
            ovf_int <= 1'b1;
          else
            cnt <= cnt + 1'b1;
        end

        if (fall_q && state_q == MEAS)
          hi_lat <= cnt;

        if (pub_meas) begin
          cap_high   <= hi_lat;
          cap_period <= cnt;
          cap_ovf    <= ovf_int;
          cap_stuck  <= 1'b0;
          cap_valid  <= 1'b1;
        end else if (pub_stuck) begin
          cap_high   <= lvl_q ? MAX_CNT : '0;
          cap_period <= '0;
          cap_ovf    <= 1'b0;
          cap_stuck  <= 1'b1;
          cap_level  <= lvl_q;
          cap_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture.
module tb_pwm_capture;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        pwm_reset, pwm_en, pwm_in;
  logic [15:0] cap_high, cap_period;
  logic        cap_valid, cap_stuck, cap_level, cap_ovf;
  logic [9:0]  h10, p10;
  logic        v10, s10, l10, o10;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] high;
    logic [15:0] period;
    logic        stuck;
    logic        level;
    logic        ovf;
    int          cyc;
  } rec_t;

  rec_t q[$];
  rec_t q10[$];
  int   rises[$];

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(SYNC), .TIMEOUT(1000)) dut (
    .pwm_clk(clk), .pwm_reset(pwm_reset), .pwm_en(pwm_en), .pwm_in(pwm_in),
    .cap_high(cap_high), .cap_period(cap_period), .cap_valid(cap_valid),
    .cap_stuck(cap_stuck), .cap_level(cap_level), .cap_ovf(cap_ovf)
  );

  pwm_capture #(.WIDTH(10), .SYNC_STAGES(SYNC), .TIMEOUT(1000)) dut10 (
    .pwm_clk(clk), .pwm_reset(pwm_reset), .pwm_en(pwm_en), .pwm_in(pwm_in),
    .cap_high(h10), .cap_period(p10), .cap_valid(v10),
    .cap_stuck(s10), .cap_level(l10), .cap_ovf(o10)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_valid) q.push_back('{cap_high, cap_period, cap_stuck, cap_level, cap_ovf, cyc});
    if (v10) q10.push_back('{{6'b0, h10}, {6'b0, p10}, s10, l10, o10, cyc});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    pwm_en    = 1'b1;
    pwm_in    = 1'b0;
    pwm_reset = 1'b1;
    step(2);
    pwm_reset = 1'b0;
    step(1);
    q.delete();
    q10.delete();
    rises.delete();
  endtask

  task automatic drive_wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      rises.push_back(cyc);
      step(h);
      pwm_in = 1'b0;
      step(l);
    end
  endtask

  task automatic test_reset;
    pwm_en    = 1'b1;
    pwm_in    = 1'b0;
    pwm_reset = 1'b1;
    step(3);
    tests++;
    if ({cap_high, cap_period, cap_valid, cap_stuck, cap_level, cap_ovf} !== 36'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%h v%b s%b l%b o%b, expected all zero",
               cap_high, cap_period, cap_valid, cap_stuck, cap_level, cap_ovf);
    end
    tests++;
    if ({h10, p10, v10, s10, l10, o10} !== 24'd0) begin
      fails++;
      $display("FAIL reset_outputs_w10: got %h/%h v%b, expected all zero", h10, p10, v10);
    end
    pwm_reset = 1'b0;
    step(1);
  endtask

  task automatic test_basic;
    do_reset();
    drive_wave(25, 75, 5);
    tests++;
    if (q.size() != 4) begin
      fails++;
      $display("FAIL basic_count: got %0d strobes, expected 4", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      tests++;
      if (q[i].high !== 16'd25 || q[i].period !== 16'd100 || q[i].ovf !== 1'b0 || q[i].stuck !== 1'b0) begin
        fails++;
        $display("FAIL basic_value[%0d]: got %0d/%0d ovf%b stuck%b, expected 25/100 ovf0 stuck0",
                 i, q[i].high, q[i].period, q[i].ovf, q[i].stuck);
      end
    end
    tests++;
    if (q.size() == 0 || q[0].cyc !== rises[1] + SYNC + 2) begin
      fails++;
      $display("FAIL basic_latency: got cycle %0d, expected %0d",
               (q.size() == 0) ? -1 : q[0].cyc, rises[1] + SYNC + 2);
    end
  endtask

  task automatic test_duty_change;
    do_reset();
    drive_wave(40, 60, 10);
    drive_wave(10, 90, 10);
    tests++;
    if (q.size() != 19) begin
      fails++;
      $display("FAIL duty_count: got %0d strobes, expected 19", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      logic [15:0] exp_h;
      exp_h = (i < 10) ? 16'd40 : 16'd10;
      tests++;
      if (q[i].high !== exp_h || q[i].period !== 16'd100) begin
        fails++;
        $display("FAIL duty_value[%0d]: got %0d/%0d, expected %0d/100", i, q[i].high, q[i].period, exp_h);
      end
    end
  endtask

  task automatic test_stuck_high;
    int n_stuck;
    int idx;
    do_reset();
    drive_wave(25, 75, 3);
    pwm_in = 1'b1;
    step(1500);
    n_stuck = 0;
    idx = -1;
    foreach (q[i]) if (q[i].stuck) begin
      n_stuck++;
      idx = i;
    end
    tests++;
    if (n_stuck != 1) begin
      fails++;
      $display("FAIL stuck_high_count: got %0d stuck strobes, expected 1", n_stuck);
    end
    tests++;
    if (idx < 0 || q[idx].level !== 1'b1 || q[idx].high !== 16'hFFFF || q[idx].period !== 16'd0) begin
      fails++;
      $display("FAIL stuck_high_value: got level%b %h/%0d, expected level1 ffff/0",
               (idx < 0) ? 1'bx : q[idx].level, (idx < 0) ? 16'hx : q[idx].high,
               (idx < 0) ? 16'hx : q[idx].period);
    end
    q.delete();
    pwm_in = 1'b0;
    step(75);
    drive_wave(25, 75, 3);
    tests++;
    if (q.size() != 2) begin
      fails++;
      $display("FAIL stuck_resume_count: got %0d strobes, expected 2", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      tests++;
      if (q[i].high !== 16'd25 || q[i].period !== 16'd100 || q[i].stuck !== 1'b0) begin
        fails++;
        $display("FAIL stuck_resume_value[%0d]: got %0d/%0d stuck%b, expected 25/100 stuck0",
                 i, q[i].high, q[i].period, q[i].stuck);
      end
    end
  endtask

  task automatic test_stuck_low_from_reset;
    do_reset();
    step(1100);
    tests++;
    if (q.size() != 1) begin
      fails++;
      $display("FAIL stuck_low_count: got %0d strobes, expected 1", q.size());
    end
    tests++;
    if (q.size() == 0 || q[0].stuck !== 1'b1 || q[0].level !== 1'b0 || q[0].high !== 16'd0 || q[0].period !== 16'd0) begin
      fails++;
      $display("FAIL stuck_low_value: wrong or missing stuck-low record, expected stuck1 level0 0/0");
    end
  endtask

  task automatic test_overflow;
    do_reset();
    drive_wave(600, 600, 3);
    tests++;
    if (q10.size() != 2) begin
      fails++;
      $display("FAIL ovf_count: got %0d strobes, expected 2", q10.size());
    end
    for (int i = 0; i < q10.size(); i++) begin
      tests++;
      if (q10[i].high !== 16'd600 || q10[i].period !== 16'd1023 || q10[i].ovf !== 1'b1) begin
        fails++;
        $display("FAIL ovf_value[%0d]: got %0d/%0d ovf%b, expected 600/1023 ovf1",
                 i, q10[i].high, q10[i].period, q10[i].ovf);
      end
    end
    tests++;
    if (q.size() != 2 || q[0].period !== 16'd1200 || q[0].ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_wide_value: got %0d strobes, expected 2 with period 1200 ovf0", q.size());
    end
  endtask

  task automatic test_glitch;
    do_reset();
    drive_wave(1, 1, 6);
    step(8);
    tests++;
    if (q.size() != 5) begin
      fails++;
      $display("FAIL glitch_count: got %0d strobes, expected 5", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      tests++;
      if (q[i].high !== 16'd1 || q[i].period !== 16'd2) begin
        fails++;
        $display("FAIL glitch_value[%0d]: got %0d/%0d, expected 1/2", i, q[i].high, q[i].period);
      end
    end
  endtask

  task automatic test_control;
    do_reset();
    drive_wave(25, 75, 2);
    pwm_in = 1'b1;
    step(25);
    pwm_in = 1'b0;
    step(30);
    pwm_en = 1'b0;
    step(10);
    tests++;
    if (q.size() != 2 || cap_high !== 16'd25 || cap_period !== 16'd100 || cap_valid !== 1'b0) begin
      fails++;
      $display("FAIL en_hold: got %0d strobes %0d/%0d v%b, expected 2 strobes 25/100 v0",
               q.size(), cap_high, cap_period, cap_valid);
    end
    pwm_en = 1'b1;
    step(45);
    q.delete();
    drive_wave(25, 75, 2);
    tests++;
    if (q.size() != 1 || q[0].high !== 16'd25 || q[0].period !== 16'd100) begin
      fails++;
      $display("FAIL en_resume: got %0d strobes, expected 1 strobe 25/100", q.size());
    end
    pwm_in = 1'b1;
    step(25);
    pwm_in = 1'b0;
    step(30);
    q.delete();
    pwm_reset = 1'b1;
    step(1);
    pwm_reset = 1'b0;
    tests++;
    if (cap_high !== 16'd0 || cap_period !== 16'd0 || cap_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_zero: got %0d/%0d v%b, expected 0/0 v0", cap_high, cap_period, cap_valid);
    end
    step(45);
    drive_wave(25, 75, 2);
    tests++;
    if (q.size() != 1 || q[0].high !== 16'd25 || q[0].period !== 16'd100) begin
      fails++;
      $display("FAIL midreset_resume: got %0d strobes, expected 1 strobe 25/100", q.size());
    end
    pwm_en = 1'b0;
    step(3);
    pwm_reset = 1'b1;
    step(1);
    pwm_reset = 1'b0;
    step(1);
    tests++;
    if (cap_high !== 16'd0 || cap_period !== 16'd0) begin
      fails++;
      $display("FAIL en_low_reset: got %0d/%0d, expected 0/0", cap_high, cap_period);
    end
    pwm_en = 1'b1;
  endtask

  initial begin
    pwm_reset = 1'b1;
    pwm_en    = 1'b1;
    pwm_in    = 1'b0;
    test_reset();
    test_basic();
    test_duty_change();
    test_stuck_high();
    test_stuck_low_from_reset();
    test_overflow();
    test_glitch();
    test_control();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
